// File: rtl/msg_pkg.sv
// Shared constants, state type and message ROM contents
// for the ASCII message stream sequencer.
package msg_pkg;

  localparam int NUM_MSG = 4;
  localparam int MAX_LEN = 16;
  localparam int SEL_W   = 2;
  localparam int IDX_W   = 4;
  localparam int DIV_W   = 8;
  localparam int LEN_W   = IDX_W + 1;

  localparam logic [LEN_W-1:0] MSG_LEN [NUM_MSG] = '{
    5'd9, 5'd7, 5'd6, 5'd13
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  // First character sits in the most significant used byte.
  function automatic logic [8*MAX_LEN-1:0] msg_str(
    input logic [SEL_W-1:0] m
  );
    case (m)
      2'd0:    msg_str = {56'h0, "Guatemala"};
      2'd1:    msg_str = {72'h0, "Quetzal"};
      2'd2:    msg_str = {80'h0, "Zacapa"};
      default: msg_str = {24'h0, "Soy de Zacapa"};
    endcase
  endfunction

endpackage

// File: rtl/msg_rom.sv
// Combinational message ROM: (msg, idx) -> (char, len).
// Indices past the message length return 0x00.
module msg_rom
  import msg_pkg::*;
(
  input  logic [SEL_W-1:0] msg,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       ch,
  output logic [LEN_W-1:0] len
);

  logic [8*MAX_LEN-1:0] str;
  logic [LEN_W-1:0]     pos;
  logic [7:0]           sel_byte;

  assign len      = MSG_LEN[msg];
  assign str      = msg_str(msg);
  assign pos      = len - 1'b1 - {1'b0, idx};
  assign sel_byte = 8'(str >> {pos, 3'b000});
  assign ch       = ({1'b0, idx} < len) ? sel_byte : 8'h00;

endmodule

// File: rtl/msg_stream_seq.sv
// Streams one stored ASCII message per start over valid/ready,
// with programmable gap, pause, abort and loop modes.
module msg_stream_seq #(
  parameter int NUM_MSG = msg_pkg::NUM_MSG,
  parameter int MAX_LEN = msg_pkg::MAX_LEN,
  parameter int SEL_W   = msg_pkg::SEL_W,
  parameter int DIV_W   = msg_pkg::DIV_W,
  parameter int IDX_W   = msg_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [DIV_W-1:0] gap,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] char_idx
);

  import msg_pkg::*;

  localparam int LW = $clog2(MAX_LEN) + 1;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] msg_q, msg_d;
  logic [SEL_W-1:0] sel_c, rom_msg;
  logic             loop_q, loop_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] nidx, rom_idx;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       rom_ch;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [LW-1:0]    rom_len;
  logic             last;

  assign sel_c = (int'(sel) >= NUM_MSG) ? '0 : sel;

  // ROM address points at whatever character is presented next.
  assign rom_msg = (state_q == IDLE) ? sel_c : msg_q;
  assign last    = ({1'b0, idx_q} == rom_len - 1'b1);
  assign nidx    = last ? '0 : idx_q + 1'b1;
  assign rom_idx = (state_q == SHOW) ? nidx :
                   (state_q == GAP)  ? idx_q : '0;

  msg_rom u_rom (
    .msg (rom_msg),
    .idx (rom_idx),
    .ch  (rom_ch),
    .len (rom_len)
  );

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    loop_d  = loop_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHOW;
          msg_d   = sel_c;
          loop_d  = loop;
          idx_d   = '0;
          data_d  = rom_ch;
          valid_d = 1'b1;
        end
      end
      SHOW: begin
        if (stop) begin
          state_d = IDLE;
          valid_d = 1'b0;
          idx_d   = '0;
          data_d  = 8'h00;
          cnt_d   = '0;
        end else if (out_ready) begin
          if (last && !loop_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            idx_d   = '0;
            data_d  = 8'h00;
            done_d  = 1'b1;
          end else begin
            done_d = last;
            idx_d  = nidx;
            if (gap == '0 && !pause) begin
              data_d = rom_ch;
            end else begin
              state_d = GAP;
              valid_d = 1'b0;
              cnt_d   = gap;
            end
          end
        end
      end
      GAP: begin
        if (stop) begin
          state_d = IDLE;
          idx_d   = '0;
          data_d  = 8'h00;
          cnt_d   = '0;
        end else if (!pause) begin
          if (cnt_q <= DIV_W'(1)) begin
            state_d = SHOW;
            valid_d = 1'b1;
            data_d  = rom_ch;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      msg_q   <= '0;
      loop_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      loop_q  <= loop_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign char_idx  = idx_q;

endmodule

// File: tb/tb_msg_stream_seq.sv
// Directed bench for msg_stream_seq: streaming, gaps,
// loop wrap, pause, stop and reset behaviour.
module tb_msg_stream_seq;

  logic       clk = 1'b0;
  logic       reset, loop, start, stop, pause;
  logic       out_valid, out_ready, busy, done;
  logic [1:0] sel;
  logic [7:0] gap, out_data;
  logic [3:0] char_idx;

  int checks = 0;
  int errors = 0;

  string g = "Guatemala";
  string q = "Quetzal";
  string z = "Zacapa";

  msg_stream_seq dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .loop      (loop),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .gap       (gap),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .char_idx  (char_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chr(input string tag,
                     input string s,
                     input int i);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(s[i]));
    chk({tag, "_idx"}, 32'(char_idx), 32'(i));
  endtask

  task automatic idle_chk(input string tag,
                          input logic exp_done);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
  endtask

  initial begin
    reset = 1'b1; sel = 2'd0; loop = 1'b0;
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    gap = 8'd0; out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    idle_chk("rst", 1'b0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_idx", 32'(char_idx), 32'h0);

    // one-shot, gap 0, one char per cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chr("t1", g, i);
      chk("t1_nodone", 32'(done), 32'd0);
      tick();
    end
    idle_chk("t1_end", 1'b1);
    tick();
    chk("t1_done_clr", 32'(done), 32'd0);

    // gap of 2 between characters
    sel = 2'd1; gap = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chr("t2", q, i);
      tick();
      if (i < 6) begin
        chk("t2_gap1", 32'(out_valid), 32'd0);
        chk("t2_gapd", 32'(done), 32'd0);
        tick();
        chk("t2_gap2", 32'(out_valid), 32'd0);
        tick();
      end
    end
    idle_chk("t2_end", 1'b1);
    tick();
    chk("t2_done_clr", 32'(done), 32'd0);

    // loop mode with stalling consumer, three passes
    sel = 2'd2; loop = 1'b1; gap = 8'd0;
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0; loop = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 6; i++) begin
        tick();
        chr("t3_hold", z, i);
        chk("t3_hold_done", 32'(done), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chr("t3_next", z, (i + 1) % 6);
        chk("t3_done", 32'(done), 32'(i == 5));
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    idle_chk("t3_stop", 1'b0);

    // select change and start while busy are ignored
    sel = 2'd0; out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chr("t4", g, i);
      if (i == 1) begin
        sel = 2'd1;
        start = 1'b1;
      end
      if (i == 2) start = 1'b0;
      tick();
    end
    idle_chk("t4_end", 1'b1);
    tick();
    idle_chk("t4_stay", 1'b0);

    // pause stretches a gap of 3 to 8 cycles
    sel = 2'd1; gap = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chr("t5_c0", q, 0);
    tick();
    chk("t5_g1", 32'(out_valid), 32'd0);
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_gp", 32'(out_valid), 32'd0);
    end
    pause = 1'b0;
    tick();
    chk("t5_g7", 32'(out_valid), 32'd0);
    tick();
    chk("t5_g8", 32'(out_valid), 32'd0);
    tick();
    chr("t5_c1", q, 1);
    out_ready = 1'b0; pause = 1'b1;
    tick();
    chr("t5_hold1", q, 1);
    tick();
    chr("t5_hold2", q, 1);
    pause = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    idle_chk("t5_stop", 1'b0);

    // stop on accept of idx 4, then reset mid-gap
    sel = 2'd0; gap = 8'd0; out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chr("t6_c4", g, 4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    idle_chk("t6_stop", 1'b0);
    chk("t6_stop_data", 32'(out_data), 32'h0);
    chk("t6_stop_idx", 32'(char_idx), 32'h0);
    gap = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chr("t6_restart", g, 0);
    tick();
    chk("t6_ingap", 32'(busy), 32'd1);
    chk("t6_ingap_v", 32'(out_valid), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_chk("t6_rst", 1'b0);
    chk("t6_rst_data", 32'(out_data), 32'h0);
    chk("t6_rst_idx", 32'(char_idx), 32'h0);
    tick();
    chk("t6_rst_nodone", 32'(done), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chr("t6_new", g, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
